// File: rtl/pll_pkg.sv
// rtl/pll_pkg.sv - shared PLL supervisor state encoding and default timing
package pll_pkg;

  typedef enum logic [2:0] {
    HOLD      = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } pll_state_t;

  // Defaults sized for the 12 MHz reference driving the 240 MHz PLL.
  localparam int PLL_RST_CYCLES    = 16;
  localparam int PLL_LOCK_TIMEOUT  = 4096;
  localparam int PLL_STABLE_CYCLES = 1024;
  localparam int PLL_MAX_RETRIES   = 4;
  localparam int PLL_CNT_W         = 16;

  // A cycle count N needs the counter to reach N-1, so N may equal 2**width.
  function automatic bit cycles_fit(input longint cycles, input int width);
    return (cycles >= 1) && (cycles <= (longint'(1) << width));
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - generic two-flop synchroniser, resets to zero
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - sequences PLL RESETB, qualifies LOCK, gates the fast-domain reset
module pll_lock_supervisor
  import pll_pkg::*;
#(
  parameter int RST_CYCLES    = PLL_RST_CYCLES,
  parameter int LOCK_TIMEOUT  = PLL_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES = PLL_STABLE_CYCLES,
  parameter int MAX_RETRIES   = PLL_MAX_RETRIES,
  parameter int CNT_W         = PLL_CNT_W
) (
  input  logic       clock_in,
  input  logic       reset,
  input  logic       locked,
  output logic       pll_resetb,
  output logic       ready,
  output logic       sys_reset,
  output logic [7:0] relock_count,
  output logic       fault
);

  localparam int RETRY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

  if (!cycles_fit(RST_CYCLES, CNT_W)) begin : g_bad_rst_cycles
    $error("RST_CYCLES must be in 1..2**CNT_W");
  end
  if (!cycles_fit(LOCK_TIMEOUT, CNT_W)) begin : g_bad_lock_timeout
    $error("LOCK_TIMEOUT must be in 1..2**CNT_W");
  end
  if (!cycles_fit(STABLE_CYCLES, CNT_W)) begin : g_bad_stable_cycles
    $error("STABLE_CYCLES must be in 1..2**CNT_W");
  end
  if (MAX_RETRIES < 0) begin : g_bad_max_retries
    $error("MAX_RETRIES must be non-negative");
  end

  pll_state_t         state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [RETRY_W-1:0] retries_q, retries_d;
  logic [7:0]         relock_d;
  logic               lock_s;

  sync_2ff #(
    .WIDTH(1)
  ) u_lock_sync (
    .clk(clock_in),
    .rst(reset),
    .d  (locked),
    .q  (lock_s)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    retries_d = retries_q;
    relock_d  = relock_count;

    case (state_q)
      HOLD: begin
        if (count_q == RST_LAST) begin
          state_d = WAIT_LOCK;
          count_d = '0;
        end else begin
          count_d = count_q + 1'b1;
        end
      end

      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = STABLE;
          count_d = '0;
        end else if (count_q == TIMEOUT_LAST) begin
          count_d = '0;
          if (retries_q == RETRY_LIMIT) begin
            state_d = FAULT;
          end else begin
            retries_d = retries_q + 1'b1;
            state_d   = HOLD;
          end
        end else begin
          count_d = count_q + 1'b1;
        end
      end

      // A drop is checked first so it wins over a window that completes on the same cycle.
      STABLE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          count_d = '0;
        end else if (count_q == STABLE_LAST) begin
          state_d   = RUN;
          count_d   = '0;
          retries_d = '0;
        end else begin
          count_d = count_q + 1'b1;
        end
      end

      RUN: begin
        if (!lock_s) begin
          state_d = HOLD;
          count_d = '0;
          if (relock_count != 8'hFF) begin
            relock_d = relock_count + 1'b1;
          end
        end
      end

      FAULT: begin
        state_d = FAULT;
      end

      default: begin
        state_d = HOLD;
        count_d = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state_q      <= HOLD;
      count_q      <= '0;
      retries_q    <= '0;
      relock_count <= 8'd0;
      pll_resetb   <= 1'b0;
      ready        <= 1'b0;
      sys_reset    <= 1'b1;
      fault        <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      retries_q    <= retries_d;
      relock_count <= relock_d;
      pll_resetb   <= (state_d == WAIT_LOCK) || (state_d == STABLE) || (state_d == RUN);
      ready        <= (state_d == RUN);
      sys_reset    <= (state_d != RUN);
      fault        <= (state_d == FAULT);
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb/tb_pll_lock_supervisor.sv - scoreboard bench for pll_lock_supervisor
module tb_pll_lock_supervisor;

  logic       clk = 1'b0;
  logic       reset;
  logic       locked;
  logic       pll_resetb;
  logic       ready;
  logic       sys_reset;
  logic [7:0] relock_count;
  logic       fault;

  pll_lock_supervisor #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (20),
    .STABLE_CYCLES(8),
    .MAX_RETRIES  (2),
    .CNT_W        (16)
  ) dut (
    .clock_in    (clk),
    .reset       (reset),
    .locked      (locked),
    .pll_resetb  (pll_resetb),
    .ready       (ready),
    .sys_reset   (sys_reset),
    .relock_count(relock_count),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  // Every output change is one vector: the cycle it appears in and the full output word.
  typedef struct {
    int          cyc;
    logic [11:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_at(input int c, input logic rb, input logic rd, input logic sr,
                           input logic f, input logic [7:0] rc);
    exp_t e;
    e.cyc = c;
    e.v   = {rb, rd, sr, f, rc};
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  // One-cycle lock drop while in RUN, then a normal re-lock.
  task automatic loss_cycle(input logic [7:0] rc);
    int d;
    d = cyc;
    locked = 1'b0;
    tick();
    locked = 1'b1;
    expect_at(d + 3, 1'b0, 1'b0, 1'b1, 1'b0, rc);
    expect_at(d + 7, 1'b1, 1'b0, 1'b1, 1'b0, rc);
    expect_at(d + 16, 1'b1, 1'b1, 1'b0, 1'b0, rc);
    wait_until(d + 19);
  endtask

  logic [11:0] prev;
  bit          first = 1'b1;
  bit          drained = 1'b0;

  always @(negedge clk) begin
    logic [11:0] cur;
    exp_t        e;
    cur = {pll_resetb, ready, sys_reset, fault, relock_count};
    if (first || cur !== prev) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_change cyc=%0d got=%h required=no change", cyc, cur);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || cur !== e.v) begin
          miscompares++;
          $display("FAIL output_vector got cyc=%0d val=%h required cyc=%0d val=%h",
                   cyc, cur, e.cyc, e.v);
        end
      end
    end
    if (done && !drained) begin
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        miscompares++;
        $display("FAIL missing_change got=none required cyc=%0d val=%h", e.cyc, e.v);
      end
      drained <= 1'b1;
    end
    first <= 1'b0;
    prev  <= cur;
  end

  initial begin
    int r, l, d, g, p, q;
    reset  = 1'b1;
    locked = 1'b0;
    expect_at(1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
    repeat (3) tick();

    // Clean bring-up.
    r = cyc;
    reset = 1'b0;
    expect_at(r + 4, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
    wait_until(r + 4);
    repeat (5) tick();
    l = cyc;
    locked = 1'b1;
    expect_at(l + 11, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    wait_until(l + 14);

    // Lock loss in RUN.
    loss_cycle(8'd1);

    // Async reset out of RUN, then a glitchy lock that must not cost a retry.
    p = cyc;
    expect_at(p, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
    reset  = 1'b1;
    locked = 1'b0;
    tick();
    tick();
    r = cyc;
    reset = 1'b0;
    expect_at(r + 4, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
    wait_until(r + 6);
    g = cyc;
    locked = 1'b1;
    expect_at(g + 15, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    repeat (3) tick();
    locked = 1'b0;
    tick();
    locked = 1'b1;
    wait_until(g + 18);

    // Async reset between edges while in STABLE.
    q = cyc;
    locked = 1'b0;
    tick();
    locked = 1'b1;
    expect_at(q + 3, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1);
    expect_at(q + 7, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1);
    wait_until(q + 10);
    #2;
    expect_at(q + 10, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
    reset = 1'b1;
    tick();
    tick();
    r = cyc;
    reset = 1'b0;
    expect_at(r + 4, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
    expect_at(r + 13, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    wait_until(r + 16);

    // Relock counter saturation.
    for (int n = 1; n <= 256; n++) begin
      loss_cycle((n > 255) ? 8'd255 : 8'(n));
    end

    // Three timed-out attempts, then a sticky fault.
    d = cyc;
    locked = 1'b0;
    expect_at(d + 3,  1'b0, 1'b0, 1'b1, 1'b0, 8'd255);
    expect_at(d + 7,  1'b1, 1'b0, 1'b1, 1'b0, 8'd255);
    expect_at(d + 27, 1'b0, 1'b0, 1'b1, 1'b0, 8'd255);
    expect_at(d + 31, 1'b1, 1'b0, 1'b1, 1'b0, 8'd255);
    expect_at(d + 51, 1'b0, 1'b0, 1'b1, 1'b0, 8'd255);
    expect_at(d + 55, 1'b1, 1'b0, 1'b1, 1'b0, 8'd255);
    expect_at(d + 75, 1'b0, 1'b0, 1'b1, 1'b1, 8'd255);
    wait_until(d + 80);
    locked = 1'b1;
    wait_until(d + 110);

    done = 1'b1;
    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
